// File: rtl/audio_front_cond.sv
// rtl/audio_front_cond.sv - ADC front-end conditioner: calibrate DC, track it, decimate, limit
//
// Purpose:
//   Converts offset-binary ADC samples to signed values and estimates the DC offset
//   from a calibration burst. It then tracks that offset with a leaky integrator
//   and removes it from every sample. The DC-free samples are boxcar-averaged and
//   decimated by 2^AVG_LOG2, and each average is limited to +/-LIMIT.
//
// Ports:
//   clk_in      in   system clock
//   RST         in   synchronous active-high reset
//   adc_data    in   12-bit unsigned offset-binary sample
//   adc_valid   in   adc_data qualifier, one sample per clk_in edge
//   enable      in   run request; low returns the block to IDLE
//   audio_out   out  12-bit signed conditioned sample, held between updates
//   audio_valid out  one-cycle strobe per audio_out update
//   clip        out  one-cycle pulse with audio_valid when the limiter acted
//   cal_done    out  high while in RUN
//   clip_cnt    out  saturating count of clipped outputs (cleared by RST only)

module audio_front_cond #(
  parameter int AVG_LOG2 = 2,
  parameter int CAL_LOG2 = 8,
  parameter int DC_SHIFT = 10,
  parameter int LIMIT    = 1800
) (
  input  logic        clk_in,
  input  logic        RST,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  input  logic        enable,
  output logic [11:0] audio_out,
  output logic        audio_valid,
  output logic        clip,
  output logic        cal_done,
  output logic [15:0] clip_cnt
);

  localparam int ACC_W  = 12 + DC_SHIFT;
  localparam int CSUM_W = 12 + CAL_LOG2;
  localparam int BSUM_W = 13 + AVG_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAL  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic signed [12:0] LIM13 = 13'(LIMIT);
  localparam logic signed [11:0] LIM12 = 12'(LIMIT);

  logic [1:0]                 state_q, state_d;
  logic [CAL_LOG2-1:0]        cal_cnt_q, cal_cnt_d;
  logic signed [CSUM_W-1:0]   cal_sum_q, cal_sum_d;
  logic signed [ACC_W-1:0]    dc_acc_q, dc_acc_d;
  logic [AVG_LOG2-1:0]        blk_cnt_q, blk_cnt_d;
  logic signed [BSUM_W-1:0]   blk_sum_q, blk_sum_d;

  // Pipeline: s1 holds the raw block average, s2 the limited value, then outputs.
  logic                       s1_valid_q, s1_valid_d;
  logic signed [12:0]         s1_avg_q, s1_avg_d;
  logic                       s2_valid_q, s2_valid_d;
  logic signed [11:0]         s2_out_q, s2_out_d;
  logic                       s2_clip_q, s2_clip_d;

  logic [11:0]                audio_out_q, audio_out_d;
  logic                       audio_valid_q, audio_valid_d;
  logic                       clip_q, clip_d;
  logic [15:0]                clip_cnt_q, clip_cnt_d;

  logic signed [11:0]         x;
  logic signed [11:0]         dc;
  logic signed [12:0]         y;
  logic signed [CSUM_W-1:0]   cal_sum_next;
  logic signed [ACC_W-1:0]    cal_ext;
  logic signed [ACC_W-1:0]    dc_load;
  logic signed [ACC_W-1:0]    dc_acc_next;
  logic signed [BSUM_W-1:0]   blk_sum_next;
  logic signed [12:0]         avg;

  // Offset binary to two's complement is just an MSB flip.
  assign x = {~adc_data[11], adc_data[10:0]};

  // dc = dc_acc >>> DC_SHIFT; the upper 12 bits are exactly that value.
  assign dc = dc_acc_q[ACC_W-1:DC_SHIFT];
  assign y  = {x[11], x} - {dc[11], dc};

  assign cal_sum_next = cal_sum_q + CSUM_W'(x);
  // Scaling the calibration mean into dc_acc's fixed-point format.
  assign cal_ext      = ACC_W'(cal_sum_next);
  assign dc_load      = cal_ext <<< (DC_SHIFT - CAL_LOG2);
  assign dc_acc_next  = dc_acc_q + ACC_W'(y);
  assign blk_sum_next = blk_sum_q + BSUM_W'(y);
  assign avg          = blk_sum_next[BSUM_W-1:AVG_LOG2];

  always_comb begin
    state_d       = state_q;
    cal_cnt_d     = cal_cnt_q;
    cal_sum_d     = cal_sum_q;
    dc_acc_d      = dc_acc_q;
    blk_cnt_d     = blk_cnt_q;
    blk_sum_d     = blk_sum_q;
    s1_valid_d    = 1'b0;
    s1_avg_d      = s1_avg_q;

    if (!enable) begin
      // Leaving for IDLE drops calibration progress and any partial block,
      // including a block whose last sample arrives this very cycle.
      state_d   = S_IDLE;
      cal_cnt_d = '0;
      cal_sum_d = '0;
      dc_acc_d  = '0;
      blk_cnt_d = '0;
      blk_sum_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CAL;
        end
        S_CAL: begin
          if (adc_valid) begin
            cal_sum_d = cal_sum_next;
            cal_cnt_d = cal_cnt_q + 1'b1;
            if (cal_cnt_q == '1) begin
              dc_acc_d  = dc_load;
              cal_sum_d = '0;
              state_d   = S_RUN;
            end
          end
        end
        S_RUN: begin
          if (adc_valid) begin
            dc_acc_d  = dc_acc_next;
            blk_sum_d = blk_sum_next;
            blk_cnt_d = blk_cnt_q + 1'b1;
            if (blk_cnt_q == '1) begin
              blk_sum_d  = '0;
              s1_valid_d = 1'b1;
              s1_avg_d   = avg;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    s2_valid_d = s1_valid_q;
    s2_out_d   = s2_out_q;
    s2_clip_d  = s2_clip_q;
    if (s1_valid_q) begin
      if (s1_avg_q > LIM13) begin
        s2_out_d  = LIM12;
        s2_clip_d = 1'b1;
      end else if (s1_avg_q < -LIM13) begin
        s2_out_d  = -LIM12;
        s2_clip_d = 1'b1;
      end else begin
        s2_out_d  = s1_avg_q[11:0];
        s2_clip_d = 1'b0;
      end
    end

    audio_valid_d = s2_valid_q;
    clip_d        = s2_valid_q & s2_clip_q;
    audio_out_d   = s2_valid_q ? s2_out_q : audio_out_q;
    clip_cnt_d    = clip_cnt_q;
    if (clip_d && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      state_q       <= S_IDLE;
      cal_cnt_q     <= '0;
      cal_sum_q     <= '0;
      dc_acc_q      <= '0;
      blk_cnt_q     <= '0;
      blk_sum_q     <= '0;
      s1_valid_q    <= 1'b0;
      s1_avg_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_out_q      <= '0;
      s2_clip_q     <= 1'b0;
      audio_out_q   <= '0;
      audio_valid_q <= 1'b0;
      clip_q        <= 1'b0;
      clip_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cal_cnt_q     <= cal_cnt_d;
      cal_sum_q     <= cal_sum_d;
      dc_acc_q      <= dc_acc_d;
      blk_cnt_q     <= blk_cnt_d;
      blk_sum_q     <= blk_sum_d;
      s1_valid_q    <= s1_valid_d;
      s1_avg_q      <= s1_avg_d;
      s2_valid_q    <= s2_valid_d;
      s2_out_q      <= s2_out_d;
      s2_clip_q     <= s2_clip_d;
      audio_out_q   <= audio_out_d;
      audio_valid_q <= audio_valid_d;
      clip_q        <= clip_d;
      clip_cnt_q    <= clip_cnt_d;
    end
  end

  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign clip        = clip_q;
  assign cal_done    = (state_q == S_RUN);
  assign clip_cnt    = clip_cnt_q;

endmodule

// File: tb/tb_audio_front_cond.sv
// tb/tb_audio_front_cond.sv - directed self-checking bench for audio_front_cond

module tb_audio_front_cond;

  logic        clk_in;
  logic        RST;
  logic [11:0] adc_data;
  logic        adc_valid;
  logic        enable;
  logic [11:0] audio_out;
  logic        audio_valid;
  logic        clip;
  logic        cal_done;
  logic [15:0] clip_cnt;

  audio_front_cond dut (
    .clk_in      (clk_in),
    .RST         (RST),
    .adc_data    (adc_data),
    .adc_valid   (adc_valid),
    .enable      (enable),
    .audio_out   (audio_out),
    .audio_valid (audio_valid),
    .clip        (clip),
    .cal_done    (cal_done),
    .clip_cnt    (clip_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int outs[$];

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sout();
    return int'($signed(audio_out));
  endfunction

  // Drive one cycle of inputs, then sample outputs 1 ns after the edge.
  task automatic step(input logic v, input logic [11:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge clk_in);
    #1;
    if (audio_valid) begin
      n_valid++;
      outs.push_back(sout());
    end
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    enable = 1'b0;
    step(1'b0, 12'd0);
    step(1'b0, 12'd0);
    RST = 1'b0;
  endtask

  task automatic calibrate(input logic [11:0] d, input int gap);
    enable = 1'b1;
    step(1'b0, d);
    for (int i = 0; i < 256; i++) begin
      step(1'b1, d);
      for (int g = 0; g < gap; g++) step(1'b0, d);
    end
  endtask

  int nv;
  logic [11:0] seq [8];

  initial begin
    RST = 1'b0; enable = 1'b0; adc_valid = 1'b0; adc_data = 12'd0;

    // Reset state
    do_reset();
    check("rst_out", sout(), 0);
    check("rst_valid", audio_valid, 0);
    check("rst_clip", clip, 0);
    check("rst_cal_done", cal_done, 0);
    check("rst_clip_cnt", clip_cnt, 0);

    // Constant 2548: dc = 500, outputs 0 every 4th cycle
    enable = 1'b1;
    for (int i = 0; i < 256; i++) step(1'b1, 12'd2548);
    check("c30_cal_before", cal_done, 0);
    step(1'b1, 12'd2548);
    check("c30_cal_after", cal_done, 1);
    for (int j = 1; j <= 20; j++) begin
      step(1'b1, 12'd2548);
      check("c30_valid", audio_valid, (j >= 6 && (j - 6) % 4 == 0) ? 1 : 0);
      if (j >= 6 && (j - 6) % 4 == 0) begin
        check("c30_out", sout(), 0);
        check("c30_clip", clip, 0);
      end
    end

    // Step 2048 -> 2148 gives +100 after two cycles
    do_reset();
    calibrate(12'd2048, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 12'd2148);
    check("c31_lat1_valid", audio_valid, 0);
    step(1'b0, 12'd0);
    check("c31_lat1b_valid", audio_valid, 0);
    step(1'b0, 12'd0);
    check("c31_valid", audio_valid, 1);
    check("c31_out", sout(), 100);
    check("c31_clip", clip, 0);
    step(1'b0, 12'd0);
    check("c31_valid_drop", audio_valid, 0);

    // Positive and negative limiting
    do_reset();
    calibrate(12'd2048, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 12'd4095);
    step(1'b0, 12'd0);
    step(1'b0, 12'd0);
    check("c32_pos_valid", audio_valid, 1);
    check("c32_pos_out", sout(), 1800);
    check("c32_pos_clip", clip, 1);
    check("c32_pos_cnt", clip_cnt, 1);
    step(1'b0, 12'd0);
    check("c32_clip_drop", clip, 0);
    check("c32_cnt_hold", clip_cnt, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 12'd0);
    step(1'b0, 12'd0);
    step(1'b0, 12'd0);
    check("c32_neg_valid", audio_valid, 1);
    check("c32_neg_out", sout(), -1800);
    check("c32_neg_clip", clip, 1);
    check("c32_neg_cnt", clip_cnt, 2);

    // Disable mid-block (4th sample on the same edge enable falls)
    do_reset();
    calibrate(12'd2048, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 12'd2148);
    step(1'b0, 12'd0);
    step(1'b0, 12'd0);
    check("c33_first_out", sout(), 100);
    nv = n_valid;
    for (int i = 0; i < 3; i++) step(1'b1, 12'd2148);
    enable = 1'b0;
    step(1'b1, 12'd2148);
    check("c33_cal_done_low", cal_done, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 12'd2148);
    check("c33_no_valid", n_valid - nv, 0);
    check("c33_out_held", sout(), 100);
    enable = 1'b1;
    step(1'b1, 12'd2048);
    for (int i = 0; i < 255; i++) step(1'b1, 12'd2048);
    check("c33_still_cal", cal_done, 0);
    step(1'b1, 12'd2048);
    check("c33_recal_done", cal_done, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 12'd2248);
    step(1'b0, 12'd0);
    check("c33_no_early", n_valid - nv, 0);
    step(1'b0, 12'd0);
    check("c33_new_valid", audio_valid, 1);
    check("c33_new_out", sout(), 200);

    // Sparse vs dense adc_valid produce the same outputs
    seq[0] = 12'd2058; seq[1] = 12'd2068; seq[2] = 12'd2078; seq[3] = 12'd2088;
    seq[4] = 12'd2040; seq[5] = 12'd2040; seq[6] = 12'd2040; seq[7] = 12'd2040;
    for (int pass = 0; pass < 2; pass++) begin
      int gap;
      gap = (pass == 0) ? 0 : 6;
      do_reset();
      calibrate(12'd2048, gap);
      outs.delete();
      for (int i = 0; i < 8; i++) begin
        step(1'b1, seq[i]);
        for (int g = 0; g < gap; g++) step(1'b0, 12'd0);
      end
      for (int i = 0; i < 4; i++) step(1'b0, 12'd0);
      check(pass == 0 ? "c34_dense_n" : "c34_sparse_n", outs.size(), 2);
      check(pass == 0 ? "c34_dense_o0" : "c34_sparse_o0", (outs.size() > 0) ? outs[0] : 9999, 25);
      check(pass == 0 ? "c34_dense_o1" : "c34_sparse_o1", (outs.size() > 1) ? outs[1] : 9999, -8);
    end

    // RST right after a block's last sample cancels its output
    do_reset();
    calibrate(12'd2048, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 12'd2148);
    nv = n_valid;
    RST = 1'b1;
    step(1'b1, 12'd2148);
    check("c35_valid", audio_valid, 0);
    check("c35_out", sout(), 0);
    check("c35_cal_done", cal_done, 0);
    check("c35_clip_cnt", clip_cnt, 0);
    RST = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 12'd2148);
    check("c35_no_valid", n_valid - nv, 0);
    check("c35_out_after", sout(), 0);
    check("c35_idle", cal_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
